// File: rtl/screen_pkg.sv
// screen_pkg: shared state type, source indices and select-width helper for the screen sequencer
package screen_pkg;
  typedef enum logic {SHOW, BLANK} state_t;
  localparam int SRC_MTM = 0;
  localparam int SRC_END = 1;
  localparam int SRC_START = 2;
  localparam int SRC_RAM = 3;
  localparam int N_SRC_STD = 4;
  function automatic int srcw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  localparam int SRCW = srcw(N_SRC_STD);
endpackage

// File: rtl/screen_prio_enc.sv
// screen_prio_enc: lowest-index-wins priority encoder, idx=DEF when no req bit is set
module screen_prio_enc #(
  parameter int N = 4,
  parameter int W = 2,
  parameter int DEF = 3
)(
  input  logic [N-1:0] req,
  output logic [W-1:0] idx
);
  always_comb begin
    idx = W'(DEF);
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) idx = W'(i);
  end
endmodule

// File: rtl/screen_sequencer.sv
// screen_sequencer: frame-synchronous screen source switch with blank frames, min hold and SRC_LAT-aligned data register
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int DATAWIDTH = 18,
  parameter int ADRESSWIDTH = 8,
  parameter int DEFAULT_SRC = SRC_RAM,
  parameter int BLANK_FRAMES = 1,
  parameter int MIN_HOLD = 2,
  parameter logic [N_SRC-1:0] FORCE_MASK = 4'b0001,
  parameter int SRC_LAT = 1,
  parameter logic [DATAWIDTH-1:0] BLANK_WORD = '0
)(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_SRC-1:0]             req,
  input  logic                         frame_start,
  input  logic [ADRESSWIDTH-1:0]       adr_in,
  output logic [N_SRC*ADRESSWIDTH-1:0] adr_out,
  input  logic [N_SRC*DATAWIDTH-1:0]   data_in,
  output logic [DATAWIDTH-1:0]         data_out,
  output logic [$clog2(N_SRC)-1:0]     active_src,
  output logic                         blanking
);
  localparam int SW = srcw(N_SRC);
  localparam int HW = $clog2(MIN_HOLD + 2);
  localparam int BW = $clog2(BLANK_FRAMES + 2);
  localparam logic [HW-1:0] HOLD_MAX = HW'(MIN_HOLD);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_FRAMES - 1);
  if (N_SRC < 2 || DEFAULT_SRC < 0 || DEFAULT_SRC >= N_SRC || SRC_LAT < 1) begin : g_bad_params
    $error("screen_sequencer: illegal N_SRC/DEFAULT_SRC/SRC_LAT");
  end
  state_t state, state_n;
  logic [SW-1:0] want, active_src_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [BW-1:0] blank_cnt, blank_n;
  logic [SW-1:0] sel_q [SRC_LAT];
  logic blank_q [SRC_LAT];
  logic sw_ok;
  screen_prio_enc #(.N(N_SRC), .W(SW), .DEF(DEFAULT_SRC)) u_enc (.req(req), .idx(want));
  assign sw_ok = (want != active_src) && (hold_cnt == HOLD_MAX || FORCE_MASK[want]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SHOW;
      active_src <= SW'(DEFAULT_SRC);
      hold_cnt <= '0;
      blank_cnt <= '0;
    end else begin
      state <= state_n;
      active_src <= active_src_n;
      hold_cnt <= hold_n;
      blank_cnt <= blank_n;
    end
  end
  always_comb begin
    state_n = state;
    active_src_n = active_src;
    hold_n = hold_cnt;
    blank_n = blank_cnt;
    if (frame_start && state == SHOW) begin
      if (!sw_ok) hold_n = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
      else if (BLANK_FRAMES == 0) begin
        active_src_n = want;
        hold_n = '0;
      end else begin
        state_n = BLANK;
        blank_n = '0;
      end
    end else if (frame_start && state == BLANK) begin
      if (blank_cnt == BLANK_LAST) begin
        state_n = SHOW;
        active_src_n = want;
        hold_n = '0;
      end else blank_n = blank_cnt + 1'b1;
    end
  end
  always_comb begin
    blanking = (state == BLANK);
    adr_out = '0;
    for (int i = 0; i < N_SRC; i++)
      if (state == SHOW && active_src == SW'(i)) adr_out[i*ADRESSWIDTH +: ADRESSWIDTH] = adr_in;
  end
  // select/blank travel alongside the address so each returned word is tagged by the source that produced it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SRC_LAT; k++) begin
        sel_q[k] <= SW'(DEFAULT_SRC);
        blank_q[k] <= 1'b0;
      end
      data_out <= BLANK_WORD;
    end else begin
      sel_q[0] <= active_src;
      blank_q[0] <= blanking;
      for (int k = 1; k < SRC_LAT; k++) begin
        sel_q[k] <= sel_q[k-1];
        blank_q[k] <= blank_q[k-1];
      end
      data_out <= blank_q[SRC_LAT-1] ? BLANK_WORD : data_in[int'(sel_q[SRC_LAT-1])*DATAWIDTH +: DATAWIDTH];
    end
  end
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: directed frames with a due-cycle scoreboard checked by a negedge monitor
module tb_screen_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = '0;
  logic frame_start = 1'b0;
  logic [7:0] adr_in = '0;
  logic [31:0] adr_out;
  logic [71:0] data_in = '0;
  logic [17:0] data_out;
  logic [1:0] active_src;
  logic blanking;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic [17:0] cw [4] = '{18'h00A00, 18'h00B00, 18'h00C00, 18'h1ABC8};
  typedef struct {
    int due;
    bit is_dat;
    logic [1:0] src;
    logic blk;
    logic [17:0] dat;
    string nm;
  } exp_t;
  exp_t q[$];
  screen_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req(req), .frame_start(frame_start), .adr_in(adr_in),
    .adr_out(adr_out), .data_in(data_in), .data_out(data_out), .active_src(active_src),
    .blanking(blanking)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk)
    for (int i = 0; i < 4; i++) data_in[i*18 +: 18] <= cw[i] ^ {10'b0, adr_out[i*8 +: 8]};
  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp_v);
    end
  endtask
  always @(negedge clk)
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].due == cyc) begin
        if (q[i].is_dat) cmp({q[i].nm, ".dat"}, 32'(data_out), 32'(q[i].dat));
        else begin
          cmp({q[i].nm, ".src"}, 32'(active_src), 32'(q[i].src));
          cmp({q[i].nm, ".blank"}, 32'(blanking), 32'(q[i].blk));
        end
        q.delete(i);
      end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push_state(input logic [1:0] s, input logic b, input string nm);
    q.push_back('{due: cyc, is_dat: 1'b0, src: s, blk: b, dat: 18'h0, nm: nm});
  endtask
  task automatic push_dat(input int d, input logic [17:0] v, input string nm);
    q.push_back('{due: cyc + d, is_dat: 1'b1, src: 2'd0, blk: 1'b0, dat: v, nm: nm});
  endtask
  task automatic drive(input int a, input logic [3:0] r);
    adr_in = 8'(a);
    req = r;
    frame_start = (a == 7);
  endtask
  task automatic run_frame(input logic [3:0] r0, input logic [3:0] r1, input logic [1:0] es,
                           input logic eb, input string nm);
    for (int a = 0; a < 8; a++) begin
      drive(a, a < 3 ? r0 : r1);
      if (a == 5) begin
        push_state(es, eb, nm);
        push_dat(2, eb ? 18'h0 : (cw[es] ^ 18'd5), nm);
      end
      tick;
    end
  endtask
  initial begin
    tick;
    tick;
    push_state(2'd3, 1'b0, "rst");
    push_dat(0, 18'h0, "rst");
    tick;
    rst_n = 1'b1;
    run_frame(4'b0000, 4'b0000, 2'd3, 1'b0, "f1_default");
    run_frame(4'b0000, 4'b0000, 2'd3, 1'b0, "f2_default");
    run_frame(4'b0000, 4'b0100, 2'd3, 1'b0, "f3_midframe_req");
    run_frame(4'b0100, 4'b0100, 2'd3, 1'b1, "f4_blank");
    run_frame(4'b0100, 4'b0110, 2'd2, 1'b0, "f5_show2");
    run_frame(4'b0110, 4'b0110, 2'd2, 1'b0, "f6_hold");
    run_frame(4'b0110, 4'b0110, 2'd2, 1'b0, "f7_hold");
    run_frame(4'b0010, 4'b0100, 2'd2, 1'b1, "f8_blank_req_change");
    run_frame(4'b0100, 4'b0001, 2'd2, 1'b0, "f9_show2_again");
    run_frame(4'b0001, 4'b0001, 2'd2, 1'b1, "f10_forced_blank");
    run_frame(4'b0001, 4'b1000, 2'd0, 1'b0, "f11_show0");
    run_frame(4'b1000, 4'b1000, 2'd0, 1'b0, "f12_hold");
    run_frame(4'b1000, 4'b1000, 2'd0, 1'b0, "f13_hold");
    for (int a = 0; a < 8; a++) begin
      if (a == 3) rst_n = 1'b0;
      if (a == 5) rst_n = 1'b1;
      drive(a, a < 3 ? 4'b1000 : 4'b0000);
      if (a == 1) push_state(2'd0, 1'b1, "f14_blank");
      if (a == 3) begin
        push_state(2'd3, 1'b0, "f14_rst_blank");
        push_dat(0, 18'h0, "f14_rst_blank");
      end
      tick;
    end
    run_frame(4'b0000, 4'b0000, 2'd3, 1'b0, "f15_after_rst");
    run_frame(4'b0000, 4'b0001, 2'd3, 1'b0, "f16_after_rst");
    run_frame(4'b0001, 4'b0001, 2'd3, 1'b1, "f17_blank");
    run_frame(4'b0001, 4'b0001, 2'd0, 1'b0, "f18_show0");
    repeat (4) tick;
    foreach (q[i]) begin
      total++;
      bad++;
      $display("FAIL %s not checked (due cycle %0d)", q[i].nm, q[i].due);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/screen_sequencer.md
Name: screen_sequencer

Overview:
Parametrised, frame-synchronous successor to the combinational screen selector. It routes the shared vector-list address (adr_in) to one of N_SRC screen sources (MTM, end screen, start screen, game RAM, ...) and returns that source's data word. Source changes happen only at frame boundaries, with optional blank frames inserted between screens and a minimum display time per screen. It sits between the vector draw engine and the screen ROMs/RAM.

Parameters:
N_SRC, 4, number of screen sources; index 0 has the highest priority
DATAWIDTH, 18, vector data word width
ADRESSWIDTH, 8, vector list address width
DEFAULT_SRC, 3, source shown when no request is active (game RAM)
BLANK_FRAMES, 1, blank frames inserted per switch; 0 = switch directly
MIN_HOLD, 2, frames a screen is held before a non-forced switch; 0 = no hold
FORCE_MASK, 4'b0001, bit i set = source i switches regardless of hold
SRC_LAT, 1, source read latency in cycles (at least 1)
BLANK_WORD, '0, word emitted while blanking (end-of-list marker)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous, active-low reset
req  in  N_SRC  per-source display request (level)
frame_start  in  1  one-cycle pulse in the last cycle of a frame, i.e. the cycle before adr_in returns to 0
adr_in  in  ADRESSWIDTH  address from the draw engine
adr_out  out  N_SRC*ADRESSWIDTH  per-source address; slice i = adr_in when i is active and state is SHOW, else 0 (combinational)
data_in  in  N_SRC*DATAWIDTH  per-source read data; slice i is valid SRC_LAT cycles after its address
data_out  out  DATAWIDTH  selected word, registered
active_src  out  $clog2(N_SRC)  currently selected source
blanking  out  1  high while in BLANK

Behaviour:
- Reset values: state=SHOW, active_src=DEFAULT_SRC, hold_cnt=0, blank_cnt=0, data_out=BLANK_WORD, select/blank pipeline cleared to DEFAULT_SRC/0.
- want (combinational) = lowest index with req set; DEFAULT_SRC if req==0.
- hold_cnt: counts frame_start pulses in SHOW since the last switch; saturates at MIN_HOLD.
- SHOW, on frame_start:
  - Switch only if want!=active_src and (hold_cnt==MIN_HOLD or FORCE_MASK[want]).
  - BLANK_FRAMES==0: active_src<=want, hold_cnt<=0.
  - Otherwise go to BLANK with blank_cnt<=0.
  - No switch: hold_cnt increments (saturating).
- BLANK, on frame_start:
  - If blank_cnt==BLANK_FRAMES-1: active_src<=want (re-evaluated, latest req), state<=SHOW, hold_cnt<=0.
  - Otherwise blank_cnt++.
  - BLANK ignores hold and force.
- No state or active_src change without frame_start. req toggling mid-frame has no effect.
- Simultaneous events: req is sampled in the frame_start cycle. A req change one cycle later waits for the next boundary.
- If want at the end of BLANK equals the old source, the block still returns to SHOW and clears hold_cnt.
- Timing:
  - adr_out is combinational from adr_in and the registered state, so a new selection applies from address 0 of the next frame.
  - (active_src, blanking) is delayed SRC_LAT cycles to get sel_d and blank_d.
  - data_out <= blank_d ? BLANK_WORD : data_in[sel_d].
  - Total latency adr_in -> data_out = SRC_LAT+1 cycles. The pipeline guarantees no word from the old source appears after the switch point.
- Reset mid-BLANK or mid-frame: immediate return to the reset values. The next frame_start is evaluated normally.
- Out-of-range DEFAULT_SRC or N_SRC<2 is illegal and fails an elaboration assertion.

Decomposition:
- Package screen_pkg holds:
  - the state enum {SHOW, BLANK}
  - source index constants SRC_MTM=0, SRC_END=1, SRC_START=2, SRC_RAM=3
  - a SRCW localparam helper
- Sub-module screen_prio_enc: N_SRC-wide lowest-index priority encoder with a default output. It is reusable elsewhere.
- The top level holds the FSM, counters, select pipeline and output register.

Test Plan:
- Reset with req=0: active_src=3, data_out=0, blanking=0. Drive adr_in=5 with data_in[3]=18'h1ABCD -> data_out=18'h1ABCD 2 cycles later.
- req=4'b0100 asserted mid-frame, hold satisfied -> no change until frame_start. Then one frame with blanking=1 and data_out=0. Then active_src=2.
- After switching to source 2, raise req[1] at the first frame_start -> no switch (hold_cnt=0<2). Switch starts at the third frame_start.
- After a switch, req[0]=1 at the first frame_start (forced) -> BLANK entered immediately, then active_src=0.
- During BLANK, change req from 4'b0010 to 4'b0100 -> at the end of BLANK, active_src=2.
- rst_n low mid-BLANK -> active_src=3, blanking=0, data_out=0 asynchronously. Normal operation resumes after release.
